ym_clk_phase_gen: RTL and testbench
===================================

Name: ym_clk_phase_gen

Overview:
Master phase generator for the ym3438/ym7101 cores. It divides MCLK into the non-overlapping two-phase enables c1/c2 that drive every shift register, latch and counter cell in the common-cell library. It also keeps the chip-cycle (slot) counter and its sync pulse. Divider changes and stop requests take effect only at a chip-clock boundary, so downstream cells never see a truncated phase.

Parameters:
DIV0, 12, MCLK ticks per chip clock for div_sel=0 (even, DIV0/2 > GAP)
DIV1, 6, ticks per chip clock for div_sel=1
DIV2, 4, ticks per chip clock for div_sel=2
GAP, 1, dead ticks at the end of each phase (>=1)
CYCLES, 24, chip clocks per slot-counter wrap
CW, 5, width of cyc (2^CW >= CYCLES)
PW, 4, width of ph_cnt (2^PW >= max DIVn)

Ports:
MCLK  in  1  sole clock, all state updates on posedge
reset  in  1  synchronous, active-high
div_sel  in  2  0/1/2 = DIV0/DIV1/DIV2, 3 = stop
c1  out  1  phase-1 enable, registered
c2  out  1  phase-2 enable, registered
ph_cnt  out  PW  tick position within the current chip clock
ph_wrap  out  1  one-tick pulse when ph_cnt is 0 (start of chip clock)
cyc  out  CW  chip-cycle number, 0..CYCLES-1
cyc0  out  1  one-tick pulse when ph_cnt=0 and cyc=0
running  out  1  0 while stopped

Behaviour:
- Reset (sampled high): N_act <= N(div_sel), where sel 3 maps to DIV0 and stopped <= 1. ph_cnt <= N_act-1, cyc <= CYCLES-1. c1, c2, ph_wrap and cyc0 <= 0. running <= (div_sel != 3).
- All outputs are registers loaded from next-state decode, so they are coherent with ph_cnt in the same cycle.
- First cycle after the edge that samples reset low (div_sel != 3): ph_cnt=0, cyc=0, c1=1, ph_wrap=1, cyc0=1.
- Within a chip clock of N=N_act ticks, c1=1 iff ph_cnt in [0, N/2-GAP-1]. c2=1 iff ph_cnt in [N/2, N-GAP-1]. c1 and c2 are never 1 together.
- ph_cnt increments by 1 each tick. At N-1 the counter reaches the wrap point.
- At the wrap point, div_sel is sampled:
  - If div_sel != 3: N_act <= N(div_sel), ph_cnt <= 0, and cyc <= (cyc==CYCLES-1) ? 0 : cyc+1.
  - If div_sel == 3: the block enters STOP. ph_cnt and cyc hold, c1=c2=0, running=0.
- STOP: the block re-evaluates div_sel every tick. The first tick with div_sel != 3 performs the normal wrap using the new N. running returns to 1 together with ph_wrap.
- div_sel changes mid chip-clock have no effect until the wrap point. No partial phases occur.
- Reset asserted mid-phase overrides everything on that edge. c1 and c2 drop to 0 in the next cycle.
- State machine: RUN <-> STOP, with transitions only at the wrap point or on reset. cyc is modulo CYCLES and never exceeds CYCLES-1.

Optional Feature:
Macro YM_CLKGEN_STEP_EN.
- Defined: adds inputs step_mode (1) and step (1). When step_mode=1, ph_cnt advances only on ticks where step=1; otherwise all registers hold. Outputs are still decoded from the held ph_cnt, but ph_wrap and cyc0 pulse only on the tick of the advance. This gives the bench and debug logic single-step phase control.
- Not defined: the ports are absent and the counter free-runs.

Decomposition:
- Package ym_clk_pkg holds:
  - div_sel encoding constants (SEL_DIV0..SEL_STOP)
  - function n_of_sel(sel) returning tick count
  - functions c1_win(cnt,n) and c2_win(cnt,n) implementing the phase windows
- One sub-module, ym_clk_div_cnt: ph_cnt with wrap detect, hold and load of N_act.
- The top level adds the cyc counter, the RUN/STOP flag and the output registers.

Test Plan:
- Reset with div_sel=0, release -> c1 high for ph_cnt 0..4, c2 high for 6..10, both low at 5 and 11. Pattern repeats every 12 ticks and cyc0 pulses every 288 ticks.
- div_sel 0->2 asserted at ph_cnt=3 -> the current 12-tick period completes. Next period is 4 ticks: c1 at tick 0, c2 at tick 2.
- div_sel=3 at ph_cnt=7 -> period completes to 11, then ph_cnt holds 11, c1=c2=0, running=0. div_sel=1 later -> the next tick shows ph_cnt=0, c1=1, ph_wrap=1, and cyc increments by 1.
- cyc=23 at wrap -> cyc=0 and cyc0=1 for one tick only. Over 50 chip clocks cyc never reaches 24.
- Reset pulsed at ph_cnt=8 (c2 high) -> c2=0 the next cycle. After release, ph_cnt=0, cyc=0, c1=1, cyc0=1.
- (YM_CLKGEN_STEP_EN) step_mode=1 with 3 step pulses from ph_cnt=0 -> ph_cnt goes to 3. Registers hold between pulses, and c1 stays 1 throughout under div_sel=0.

Source files
------------

// File: rtl/ym_clk_pkg.sv
// Shared constants and phase-window helpers for the ym master phase generator.
// Optional build macro: YM_CLKGEN_STEP_EN (single-step phase control).
package ym_clk_pkg;

    localparam int PW     = 4;
    localparam int CW     = 5;
    localparam int CYCLES = 24;

    localparam logic [PW-1:0] DIV0   = PW'(12);
    localparam logic [PW-1:0] DIV1   = PW'(6);
    localparam logic [PW-1:0] DIV2   = PW'(4);
    localparam logic [PW-1:0] GAP    = PW'(1);
    localparam logic [PW-1:0] PH_ONE = PW'(1);

    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);

    localparam logic [1:0] SEL_DIV0 = 2'd0;
    localparam logic [1:0] SEL_DIV1 = 2'd1;
    localparam logic [1:0] SEL_DIV2 = 2'd2;
    localparam logic [1:0] SEL_STOP = 2'd3;

    typedef enum logic {
        ST_RUN,
        ST_STOP
    } state_e;

    // Stop maps to DIV0 so a reset under stop still loads a sane period.
    function automatic logic [PW-1:0] n_of_sel(input logic [1:0] sel);
        logic [PW-1:0] n;
        case (sel)
            SEL_DIV0: n = DIV0;
            SEL_DIV1: n = DIV1;
            SEL_DIV2: n = DIV2;
            default:  n = DIV0;
        endcase
        return n;
    endfunction

    function automatic logic c1_win(input logic [PW-1:0] cnt,
                                    input logic [PW-1:0] n);
        return cnt < ((n >> 1) - GAP);
    endfunction

    function automatic logic c2_win(input logic [PW-1:0] cnt,
                                    input logic [PW-1:0] n);
        return (cnt >= (n >> 1)) && (cnt < (n - GAP));
    endfunction

endpackage

// File: rtl/ym_clk_div_cnt.sv
// Tick counter within one chip clock: wrap detect, hold, and N_act load.
// The period register only changes at a wrap, so phases are never cut short.
module ym_clk_div_cnt
    import ym_clk_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          adv_i,
    input  logic          stop_i,
    input  logic [1:0]    sel_i,
    output logic [PW-1:0] ph_q_o,
    output logic [PW-1:0] ph_d_o,
    output logic [PW-1:0] n_d_o,
    output logic          load_o,
    output logic          halt_o
);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic [PW-1:0] n_q;
    logic [PW-1:0] n_d;
    logic [PW-1:0] n_sel;
    logic          at_wrap;
    logic          load;
    logic          halt;

    // While stopped the counter sits at its wrap point and re-tests div_sel.
    always_comb begin
        n_sel   = n_of_sel(sel_i);
        at_wrap = stop_i || (ph_q == (n_q - PH_ONE));
        load    = adv_i && at_wrap && (sel_i != SEL_STOP);
        halt    = adv_i && at_wrap && (sel_i == SEL_STOP);
        ph_d    = ph_q;
        n_d     = n_q;
        if (load) begin
            ph_d = '0;
            n_d  = n_sel;
        end else if (adv_i && !at_wrap) begin
            ph_d = ph_q + PH_ONE;
        end
    end

    // Reset parks the counter on the last tick so release wraps to 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q  <= n_sel;
            ph_q <= n_sel - PH_ONE;
        end else begin
            n_q  <= n_d;
            ph_q <= ph_d;
        end
    end

    assign ph_q_o = ph_q;
    assign ph_d_o = ph_d;
    assign n_d_o  = n_d;
    assign load_o = load;
    assign halt_o = halt;

endmodule

// File: rtl/ym_clk_phase_gen.sv
// Master two-phase (c1/c2) enable generator with chip-cycle slot counter.
// Optional build macro: YM_CLKGEN_STEP_EN adds step_mode/step inputs.
module ym_clk_phase_gen
    import ym_clk_pkg::*;
(
    input  logic          MCLK,
    input  logic          reset,
    input  logic [1:0]    div_sel,
`ifdef YM_CLKGEN_STEP_EN
    input  logic          step_mode,
    input  logic          step,
`endif
    output logic          c1,
    output logic          c2,
    output logic [PW-1:0] ph_cnt,
    output logic          ph_wrap,
    output logic [CW-1:0] cyc,
    output logic          cyc0,
    output logic          running
);

    logic          adv;
    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic [PW-1:0] n_d;
    logic          load;
    logic          halt;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_d;
    logic          run_d;
    logic          c1_q;
    logic          c2_q;
    logic          wrap_q;
    logic          cyc0_q;
    logic          run_q;
    logic          c1_d;
    logic          c2_d;
    logic          cyc0_d;

`ifdef YM_CLKGEN_STEP_EN
    assign adv = !step_mode || step;
`else
    assign adv = 1'b1;
`endif

    ym_clk_div_cnt u_div_cnt (
        .clk_i  (MCLK),
        .rst_i  (reset),
        .adv_i  (adv),
        .stop_i (state_q == ST_STOP),
        .sel_i  (div_sel),
        .ph_q_o (ph_q),
        .ph_d_o (ph_d),
        .n_d_o  (n_d),
        .load_o (load),
        .halt_o (halt)
    );

    // Next-state decode so every output register matches ph_cnt's cycle.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_RUN;
        end else if (halt) begin
            state_d = ST_STOP;
        end
        cyc_d = cyc_q;
        if (load) begin
            cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + CYC_ONE;
        end
        run_d  = (state_d == ST_RUN);
        c1_d   = run_d && c1_win(ph_d, n_d);
        c2_d   = run_d && c2_win(ph_d, n_d);
        cyc0_d = load && (cyc_d == '0);
    end

    // RUN/STOP state, slot counter and all registered outputs.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q <= ST_STOP;
            cyc_q   <= CYC_LAST;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            wrap_q  <= 1'b0;
            cyc0_q  <= 1'b0;
            run_q   <= (div_sel != SEL_STOP);
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            wrap_q  <= load;
            cyc0_q  <= cyc0_d;
            run_q   <= run_d;
        end
    end

    assign c1      = c1_q;
    assign c2      = c2_q;
    assign ph_cnt  = ph_q;
    assign ph_wrap = wrap_q;
    assign cyc     = cyc_q;
    assign cyc0    = cyc0_q;
    assign running = run_q;

endmodule

// File: tb/tb_ym_clk_phase_gen.sv
// Randomized bench for ym_clk_phase_gen against a tick-level reference model.
// Build with YM_CLKGEN_STEP_EN to also exercise single-step control.
module tb_ym_clk_phase_gen;

    localparam int NCYC = 24;
    localparam int GAPT = 1;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] div_sel = 2'd0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;

    logic       c1;
    logic       c2;
    logic [3:0] ph_cnt;
    logic       ph_wrap;
    logic [4:0] cyc;
    logic       cyc0;
    logic       running;

    int errors = 0;
    int checks = 0;

    int m_n;
    int m_p;
    int m_cyc;
    bit m_stop;
    bit e_c1;
    bit e_c2;
    bit e_wrap;
    bit e_cyc0;
    bit e_run;

    always #5 MCLK = ~MCLK;

    ym_clk_phase_gen dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .div_sel   (div_sel),
`ifdef YM_CLKGEN_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .c1        (c1),
        .c2        (c2),
        .ph_cnt    (ph_cnt),
        .ph_wrap   (ph_wrap),
        .cyc       (cyc),
        .cyc0      (cyc0),
        .running   (running)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int period(input int s);
        return (s == 1) ? 6 : (s == 2) ? 4 : 12;
    endfunction

    // Chip-clock rules: count ticks, restart at N-1, park while stop asked.
    task automatic model_step(input bit r, input int s, input bit adv);
        bit w;
        w = 1'b0;
        if (r) begin
            m_n    = period(s);
            m_p    = m_n - 1;
            m_cyc  = NCYC - 1;
            m_stop = 1'b1;
            e_c1   = 1'b0;
            e_c2   = 1'b0;
            e_wrap = 1'b0;
            e_cyc0 = 1'b0;
            e_run  = (s != 3);
            return;
        end
        if (!adv) begin
            e_wrap = 1'b0;
            e_cyc0 = 1'b0;
            return;
        end
        if (m_stop || m_p == m_n - 1) begin
            if (s == 3) begin
                m_stop = 1'b1;
            end else begin
                m_stop = 1'b0;
                m_n    = period(s);
                m_p    = 0;
                m_cyc  = (m_cyc + 1) % NCYC;
                w      = 1'b1;
            end
        end else begin
            m_p = m_p + 1;
        end
        e_c1   = !m_stop && (m_p <= m_n / 2 - GAPT - 1);
        e_c2   = !m_stop && (m_p >= m_n / 2) && (m_p <= m_n - GAPT - 1);
        e_wrap = w;
        e_cyc0 = w && (m_cyc == 0);
        e_run  = !m_stop;
    endtask

    task automatic tick(input bit r, input logic [1:0] s);
        bit adv;
        reset   = r;
        div_sel = s;
        @(posedge MCLK);
`ifdef YM_CLKGEN_STEP_EN
        adv = !step_mode || step;
`else
        adv = 1'b1;
`endif
        model_step(r, int'(s), adv);
        #1;
        chk("c1", c1, e_c1);
        chk("c2", c2, e_c2);
        chk("ph_cnt", ph_cnt, m_p);
        chk("cyc", cyc, m_cyc);
        chk("ph_wrap", ph_wrap, e_wrap);
        chk("cyc0", cyc0, e_cyc0);
        chk("running", running, e_run);
        chk("no_overlap", c1 & c2, 0);
        chk("cyc_range", cyc < NCYC, 1);
    endtask

    task automatic run_until(input int p, input logic [1:0] s);
        int k;
        k = 0;
        while (!(m_p == p && !m_stop) && k < 60) begin
            tick(1'b0, s);
            k++;
        end
        chk("reach_ph", ph_cnt, p);
    endtask

    initial begin
        logic [1:0] sel;
        bit         r;

        repeat (3) tick(1'b1, 2'd0);
        tick(1'b0, 2'd0);
        chk("rel_ph0", ph_cnt, 0);
        chk("rel_cyc0", cyc0, 1);
        repeat (300) tick(1'b0, 2'd0);

        run_until(3, 2'd0);
        repeat (20) tick(1'b0, 2'd2);

        repeat (13) tick(1'b0, 2'd0);
        run_until(7, 2'd0);
        repeat (15) tick(1'b0, 2'd3);
        chk("stop_hold", ph_cnt, 11);
        repeat (40) tick(1'b0, 2'd1);

        repeat (300) tick(1'b0, 2'd1);

        repeat (13) tick(1'b0, 2'd0);
        run_until(8, 2'd0);
        tick(1'b1, 2'd0);
        chk("rst_c2", c2, 0);
        tick(1'b1, 2'd0);
        repeat (30) tick(1'b0, 2'd0);

        tick(1'b1, 2'd3);
        repeat (5) tick(1'b0, 2'd3);
        repeat (10) tick(1'b0, 2'd2);

`ifdef YM_CLKGEN_STEP_EN
        repeat (2) tick(1'b1, 2'd0);
        tick(1'b0, 2'd0);
        step_mode = 1'b1;
        step = 1'b0;
        repeat (3) begin
            repeat (2) tick(1'b0, 2'd0);
            step = 1'b1;
            tick(1'b0, 2'd0);
            step = 1'b0;
        end
        tick(1'b0, 2'd0);
        chk("step_ph", ph_cnt, 3);
        chk("step_c1", c1, 1);
        repeat (200) begin
            step = 1'($urandom_range(0, 1));
            tick(1'b0, 2'($urandom_range(0, 2)));
        end
        step = 1'b0;
        step_mode = 1'b0;
`endif

        sel = 2'd0;
        repeat (3000) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) begin
                sel = 2'($urandom_range(0, 3));
            end
            tick(r, sel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
